// File: rtl/ch_timestamp_capture.sv
// ch_timestamp_capture: per-channel coarse timestamp engine in the FCLK domain.
//
// Ports
//   FCLK           sampling clock, all state on posedge
//   RSTB           asynchronous active-low reset
//   START          1-cycle pulse: clear all results and arm
//   STOP           1-cycle pulse: latch stop time into CE and finish
//   HIT            1-cycle pulse: qualified trigger hit
//   MODE[1:0]      00 one buffer/event, 01 two, 11 four, 10 behaves as 00
//   CA..CD         hit timestamps, CE stop timestamp
//   HIT_CNT        number of hits recorded, saturates at mode capacity
//   ARMED / DONE   registered state flags
//   WRAP           sticky: coarse counter wrapped while armed
module ch_timestamp_capture #(
    parameter int CNT_W     = 10,
    parameter int HIT_CNT_W = 3
) (
    input  logic                 FCLK,
    input  logic                 RSTB,
    input  logic                 START,
    input  logic                 STOP,
    input  logic                 HIT,
    input  logic [1:0]           MODE,
    output logic [CNT_W-1:0]     CA,
    output logic [CNT_W-1:0]     CB,
    output logic [CNT_W-1:0]     CC,
    output logic [CNT_W-1:0]     CD,
    output logic [CNT_W-1:0]     CE,
    output logic [HIT_CNT_W-1:0] HIT_CNT,
    output logic                 ARMED,
    output logic                 DONE,
    output logic                 WRAP
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DONE} state_t;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [CNT_W-1:0]     slot_q [4];
    logic [CNT_W-1:0]     ce_q;
    logic [HIT_CNT_W-1:0] hcnt_q;
    logic [HIT_CNT_W-1:0] hcnt_d;
    logic [HIT_CNT_W-1:0] cap;
    logic [1:0]           mode_q;
    logic                 armed_q;
    logic                 done_q;
    logic                 wrap_q;
    logic                 hit_ok;
    logic [3:0]           we;

    // mode_q only ever holds 00, 01 or 11 (10 is folded to 00 at START)
    always_comb begin
        cap    = mode_q == 2'b11 ? HIT_CNT_W'(1) : mode_q == 2'b01 ? HIT_CNT_W'(2) : HIT_CNT_W'(4);
        hit_ok = HIT && !START && state_q == S_ARMED && hcnt_q < cap;
        we     = !hit_ok ? 4'b0000 :
                 mode_q == 2'b11 ? 4'b1111 :
                 mode_q == 2'b01 ? (hcnt_q[0] ? 4'b1100 : 4'b0011) :
                 4'b0001 << hcnt_q[1:0];
        cnt_d  = cnt_q + CNT_W'(1);
        hcnt_d = hcnt_q + HIT_CNT_W'(1);
    end

    always_ff @(posedge FCLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            ce_q    <= '0;
            hcnt_q  <= '0;
            mode_q  <= 2'b00;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (START) begin
            // START overrides any coincident HIT or STOP
            state_q <= S_ARMED;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            ce_q    <= '0;
            hcnt_q  <= '0;
            mode_q  <= MODE == 2'b10 ? 2'b00 : MODE;
            armed_q <= 1'b1;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (state_q == S_ARMED) begin
            for (int i = 0; i < 4; i++) if (we[i]) slot_q[i] <= cnt_q;
            if (hit_ok) hcnt_q <= hcnt_d;
            if (STOP) begin
                // counter freezes on the STOP cycle, so CE and a coincident hit agree
                ce_q    <= cnt_q;
                state_q <= S_DONE;
                armed_q <= 1'b0;
                done_q  <= 1'b1;
            end else begin
                cnt_q <= cnt_d;
                if (&cnt_q) wrap_q <= 1'b1;
            end
        end
    end

    assign CA      = slot_q[0];
    assign CB      = slot_q[1];
    assign CC      = slot_q[2];
    assign CD      = slot_q[3];
    assign CE      = ce_q;
    assign HIT_CNT = hcnt_q;
    assign ARMED   = armed_q;
    assign DONE    = done_q;
    assign WRAP    = wrap_q;

endmodule

// File: tb/tb_ch_timestamp_capture.sv
// tb_ch_timestamp_capture: directed table-driven bench for ch_timestamp_capture.
module tb_ch_timestamp_capture;

    logic       FCLK = 1'b0;
    logic       RSTB = 1'b0;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HIT = 1'b0;
    logic [1:0] MODE = 2'b00;
    logic [9:0] CA, CB, CC, CD, CE;
    logic [2:0] HIT_CNT;
    logic       ARMED, DONE, WRAP;

    int checks = 0;
    int errors = 0;

    ch_timestamp_capture #(.CNT_W(10), .HIT_CNT_W(3)) dut (
        .FCLK(FCLK), .RSTB(RSTB), .START(START), .STOP(STOP), .HIT(HIT), .MODE(MODE),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE),
        .HIT_CNT(HIT_CNT), .ARMED(ARMED), .DONE(DONE), .WRAP(WRAP)
    );

    always #5 FCLK = ~FCLK;

    typedef struct packed {
        logic [1:0]        mode;
        logic [4:0][10:0]  hits;   // elapsed armed cycles of each HIT, 11'h7FF = unused
        logic [10:0]       stop;   // elapsed armed cycle of STOP
        logic [4:0][9:0]   e;      // expected CA..CE (index 0 = CA)
        logic [2:0]        ehc;
        logic              ewrap;
    } vec_t;

    localparam logic [10:0] NO = 11'h7FF;

    vec_t v [5];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic check_all(input string p, input logic [4:0][9:0] e, input logic [2:0] hc,
                             input logic ar, input logic dn, input logic wr);
        chk({p, " CA"}, 32'(CA), 32'(e[0]));
        chk({p, " CB"}, 32'(CB), 32'(e[1]));
        chk({p, " CC"}, 32'(CC), 32'(e[2]));
        chk({p, " CD"}, 32'(CD), 32'(e[3]));
        chk({p, " CE"}, 32'(CE), 32'(e[4]));
        chk({p, " HIT_CNT"}, 32'(HIT_CNT), 32'(hc));
        chk({p, " ARMED"}, 32'(ARMED), 32'(ar));
        chk({p, " DONE"}, 32'(DONE), 32'(dn));
        chk({p, " WRAP"}, 32'(WRAP), 32'(wr));
    endtask

    initial begin
        v[0] = '{mode: 2'b00, hits: {NO, 11'd30, 11'd20, 11'd9, 11'd5}, stop: 11'd40,
                 e: {10'd40, 10'd30, 10'd20, 10'd9, 10'd5}, ehc: 3'd4, ewrap: 1'b0};
        v[1] = '{mode: 2'b01, hits: {NO, NO, 11'd11, 11'd7, 11'd3}, stop: 11'd15,
                 e: {10'd15, 10'd7, 10'd7, 10'd3, 10'd3}, ehc: 3'd2, ewrap: 1'b0};
        v[2] = '{mode: 2'b11, hits: {NO, NO, NO, NO, 11'd100}, stop: 11'd1030,
                 e: {10'd6, 10'd100, 10'd100, 10'd100, 10'd100}, ehc: 3'd1, ewrap: 1'b1};
        v[3] = '{mode: 2'b00, hits: {NO, NO, NO, NO, 11'd12}, stop: 11'd12,
                 e: {10'd12, 10'd0, 10'd0, 10'd0, 10'd12}, ehc: 3'd1, ewrap: 1'b0};
        v[4] = '{mode: 2'b10, hits: {11'd10, 11'd8, 11'd6, 11'd4, 11'd2}, stop: 11'd11,
                 e: {10'd11, 10'd8, 10'd6, 10'd4, 10'd2}, ehc: 3'd4, ewrap: 1'b0};

        repeat (2) @(negedge FCLK);
        check_all("reset", '0, 3'd0, 1'b0, 1'b0, 1'b0);
        RSTB = 1'b1;
        @(negedge FCLK);
        HIT = 1'b1;
        STOP = 1'b1;
        @(negedge FCLK);
        HIT = 1'b0;
        STOP = 1'b0;
        check_all("idle_ignore", '0, 3'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            MODE = v[i].mode;
            START = 1'b1;
            @(negedge FCLK);
            START = 1'b0;
            for (int t = 0; t <= int'(v[i].stop); t++) begin
                HIT = 1'b0;
                for (int k = 0; k < 5; k++) if (int'(v[i].hits[k]) == t) HIT = 1'b1;
                STOP = (t == int'(v[i].stop));
                @(negedge FCLK);
            end
            HIT = 1'b0;
            STOP = 1'b0;
            check_all($sformatf("vec%0d", i), v[i].e, v[i].ehc, 1'b0, 1'b1, v[i].ewrap);
        end

        // DONE holds against HIT and STOP
        HIT = 1'b1;
        STOP = 1'b1;
        @(negedge FCLK);
        HIT = 1'b0;
        STOP = 1'b0;
        check_all("done_hold", v[4].e, 3'd4, 1'b0, 1'b1, 1'b0);

        // START with a coincident HIT clears everything and drops the hit
        MODE = 2'b00;
        START = 1'b1;
        HIT = 1'b1;
        @(negedge FCLK);
        START = 1'b0;
        HIT = 1'b0;
        check_all("start_hit", '0, 3'd0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge FCLK);
        HIT = 1'b1;
        @(negedge FCLK);
        HIT = 1'b0;
        chk("restart CA", 32'(CA), 32'd3);
        chk("restart HIT_CNT", 32'(HIT_CNT), 32'd1);

        // async reset mid-acquisition with two hits recorded
        START = 1'b1;
        @(negedge FCLK);
        START = 1'b0;
        HIT = 1'b1;
        repeat (2) @(negedge FCLK);
        HIT = 1'b0;
        chk("pre_rst HIT_CNT", 32'(HIT_CNT), 32'd2);
        chk("pre_rst CB", 32'(CB), 32'd1);
        #2 RSTB = 1'b0;
        #1 check_all("async_rst", '0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge FCLK);
        RSTB = 1'b1;
        HIT = 1'b1;
        @(negedge FCLK);
        HIT = 1'b0;
        check_all("post_rst", '0, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
